// File: rtl/esm_pkg.sv
// Shared types and helpers for the ESM issue scheduler.
package esm_pkg;

    // Scheduler sequencing states.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_SELECT  = 3'd2,
        S_CAPTURE = 3'd3,
        S_ISSUE   = 3'd4
    } esm_sched_state_t;

    // Default settle time: the core resynchronizes the snapshot through two flops.
    localparam int ESM_SETTLE_DEFAULT = 2;

    // Index width for a buffer of n slots (at least one bit).
    function automatic int esm_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/esm_slot_mask.sv
// Pending-slot register: per-bit set/clear with flush > set > clear priority.
module esm_slot_mask
    import esm_pkg::*;
#(
    parameter  int bs = 16,
    localparam int IW = esm_idx_w(bs)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          set_en,
    input  logic [IW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [IW-1:0] clr_idx,
    output logic [bs-1:0] pending
);

    for (genvar i = 0; i < bs; i++) begin : g_bit
        logic set_hit, clr_hit;
        assign set_hit = set_en && (set_idx == IW'(i));
        assign clr_hit = clr_en && (clr_idx == IW'(i));

        // A set on the same cycle as the issue clear keeps the bit: the slot was re-armed.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)          pending[i] <= 1'b0;
            else if (flush)    pending[i] <= 1'b0;
            else if (set_hit)  pending[i] <= 1'b1;
            else if (clr_hit)  pending[i] <= 1'b0;
        end
    end

endmodule

// File: rtl/esm_issue_scheduler.sv
// Issue scheduler: snapshots pending slots, lets the core settle, strobes
// proceed, validates its choice and hands it to execution via valid/ready.
module esm_issue_scheduler
    import esm_pkg::*;
#(
    parameter  int bs     = 16,
    parameter  int SETTLE = ESM_SETTLE_DEFAULT,
    parameter  int CW     = 16,
    localparam int IW     = esm_idx_w(bs)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          slot_set,
    input  logic [IW-1:0] slot_set_index,
    output logic [0:bs-1] core_independent_instr,
    output logic [IW-1:0] core_buffer_index,
    output logic          core_proceed,
    input  logic [IW-1:0] core_next_buffer_index,
    input  logic          core_valid_count,
    output logic          issue_valid,
    output logic [IW-1:0] issue_index,
    input  logic          issue_ready,
    output logic [bs-1:0] pending,
    output logic [CW-1:0] issued_count,
    output logic [CW-1:0] miss_count,
    output logic          busy
);

    localparam int SCW = $clog2(SETTLE + 1);

    esm_sched_state_t state, next_state;
    logic [bs-1:0]    snapshot;
    logic [SCW-1:0]   settle_cnt;
    logic             accept, handshake, miss;

    esm_slot_mask #(.bs(bs)) u_mask (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .set_en  (slot_set),
        .set_idx (slot_set_index),
        .clr_en  (handshake),
        .clr_idx (issue_index),
        .pending (pending)
    );

    // Core sees the snapshot MSB-first: port bit i is slot i.
    for (genvar i = 0; i < bs; i++) begin : g_snap
        assign core_independent_instr[i] = snapshot[i];
    end

    assign busy = (state != S_IDLE);

    // Choice must still be in both the snapshot and the live mask (stale guard).
    assign accept    = core_valid_count && snapshot[core_next_buffer_index]
                       && pending[core_next_buffer_index];
    assign handshake = (state == S_ISSUE) && issue_ready && !flush;
    assign miss      = (state == S_CAPTURE) && !accept && !flush;

    // Next-state logic; flush overrides every transition.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (|pending) next_state = S_WAIT;
            S_WAIT:    if (settle_cnt == SCW'(SETTLE - 1)) next_state = S_SELECT;
            S_SELECT:  next_state = S_CAPTURE;
            S_CAPTURE: next_state = accept ? S_ISSUE : S_IDLE;
            S_ISSUE:   if (issue_ready) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
        if (flush) next_state = S_IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    // Snapshot, settle counter, indices, registered strobes and statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snapshot          <= '0;
            settle_cnt        <= '0;
            core_buffer_index <= '0;
            issue_index       <= '0;
            core_proceed      <= 1'b0;
            issue_valid       <= 1'b0;
            issued_count      <= '0;
            miss_count        <= '0;
        end else begin
            if (state == S_IDLE && next_state == S_WAIT) begin
                snapshot   <= pending;
                settle_cnt <= '0;
            end else if (state == S_WAIT) begin
                settle_cnt <= settle_cnt + SCW'(1);
            end
            if (state == S_CAPTURE && accept) issue_index <= core_next_buffer_index;
            if (handshake) begin
                core_buffer_index <= issue_index;
                issued_count      <= issued_count + CW'(1);
            end
            if (miss) miss_count <= miss_count + CW'(1);
            core_proceed <= (next_state == S_SELECT);
            issue_valid  <= (next_state == S_ISSUE);
        end
    end

endmodule

// File: tb/tb_esm_issue_scheduler.sv
// Scoreboard bench for esm_issue_scheduler: directed vectors, expected issue
// indices queued by stimulus and checked by a separate handshake monitor.
module tb_esm_issue_scheduler;
    import esm_pkg::*;

    localparam int BS = 16;
    localparam int IW = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush, slot_set, core_valid_count, issue_ready;
    logic [IW-1:0] slot_set_index, core_next_buffer_index;
    logic [0:BS-1] core_independent_instr;
    logic [IW-1:0] core_buffer_index, issue_index;
    logic          core_proceed, issue_valid, busy;
    logic [BS-1:0] pending;
    logic [CW-1:0] issued_count, miss_count;

    int vectors = 0;
    int miscompares = 0;
    logic [IW-1:0] exp_q[$];

    esm_issue_scheduler #(.bs(BS), .SETTLE(2), .CW(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .slot_set(slot_set), .slot_set_index(slot_set_index),
        .core_independent_instr(core_independent_instr),
        .core_buffer_index(core_buffer_index), .core_proceed(core_proceed),
        .core_next_buffer_index(core_next_buffer_index),
        .core_valid_count(core_valid_count),
        .issue_valid(issue_valid), .issue_index(issue_index), .issue_ready(issue_ready),
        .pending(pending), .issued_count(issued_count), .miss_count(miss_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted handshake must match the next queued index.
    always @(negedge clk) begin
        if (rst && issue_valid && issue_ready && !flush) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_issue: got index %0d, expected none", issue_index);
            end else begin
                logic [IW-1:0] e;
                e = exp_q.pop_front();
                if (issue_index !== e) begin
                    miscompares++;
                    $display("FAIL issue_index: got %0d, expected %0d", issue_index, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; flush = 1'b0; slot_set = 1'b0; slot_set_index = '0;
        core_valid_count = 1'b0; core_next_buffer_index = '0; issue_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Pulse slot_set for one edge; that edge is "edge 0" of the latency count.
    task automatic set_slot(input logic [IW-1:0] idx);
        slot_set = 1'b1; slot_set_index = idx;
        tick();
        slot_set = 1'b0;
    endtask

    logic [4:0] exp_pro, exp_vld;

    initial begin
        // ---- reset state
        do_reset();
        check("rst_busy", 32'(busy), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_snapshot", 32'(core_independent_instr), 0);
        check("rst_proceed", 32'(core_proceed), 0);
        check("rst_issue_valid", 32'(issue_valid), 0);
        check("rst_counts", {issued_count, miss_count}, 0);

        // ---- single slot 5: proceed after edge 3 (4th cycle), valid after edge 5
        issue_ready = 1'b1; core_valid_count = 1'b1; core_next_buffer_index = 4'd5;
        exp_q.push_back(4'd5);
        set_slot(4'd5);
        check("t1_pending", 32'(pending), 32'h0020);
        exp_pro = 5'b00100; exp_vld = 5'b10000;   // bit k-1 = after edge k
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("t1_proceed_e%0d", k), 32'(core_proceed), 32'(exp_pro[k-1]));
            check($sformatf("t1_valid_e%0d", k), 32'(issue_valid), 32'(exp_vld[k-1]));
            if (k == 1) check("t1_snapshot", 32'(core_independent_instr), 32'h0400);
        end
        check("t1_issue_index", 32'(issue_index), 5);
        tick();
        check("t1_pending_after", 32'(pending), 0);
        check("t1_cbi", 32'(core_buffer_index), 5);
        check("t1_issued", 32'(issued_count), 1);
        check("t1_busy", 32'(busy), 0);

        // ---- invalid choice on slot 3
        do_reset();
        core_valid_count = 1'b0; core_next_buffer_index = 4'd3; issue_ready = 1'b1;
        set_slot(4'd3);
        repeat (5) tick();
        check("t2_miss", 32'(miss_count), 1);
        check("t2_busy_idle", 32'(busy), 0);
        check("t2_pending", 32'(pending), 32'h0008);
        check("t2_valid", 32'(issue_valid), 0);
        tick();
        check("t2_resnap", 32'(busy), 1);

        // ---- stale index: pending {2}, core returns 7
        do_reset();
        core_valid_count = 1'b1; core_next_buffer_index = 4'd7; issue_ready = 1'b1;
        set_slot(4'd2);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("t3_valid_e%0d", k), 32'(issue_valid), 0);
        end
        check("t3_miss", 32'(miss_count), 1);
        check("t3_issued", 32'(issued_count), 0);

        // ---- backpressure on slot 2
        do_reset();
        core_valid_count = 1'b1; core_next_buffer_index = 4'd2; issue_ready = 1'b0;
        set_slot(4'd2);
        repeat (5) tick();
        for (int k = 0; k < 10; k++) begin
            check("t4_hold_valid", 32'(issue_valid), 1);
            check("t4_hold_index", 32'(issue_index), 2);
            tick();
        end
        exp_q.push_back(4'd2);
        issue_ready = 1'b1;
        tick();
        check("t4_issued", 32'(issued_count), 1);
        check("t4_valid_low", 32'(issue_valid), 0);
        check("t4_pending", 32'(pending), 0);

        // ---- set-wins collision on slot 2
        do_reset();
        core_valid_count = 1'b1; core_next_buffer_index = 4'd2; issue_ready = 1'b0;
        set_slot(4'd2);
        repeat (5) tick();
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd2);
        issue_ready = 1'b1;
        set_slot(4'd2);
        check("t5_pending_kept", 32'(pending), 32'h0004);
        check("t5_issued1", 32'(issued_count), 1);
        check("t5_cbi", 32'(core_buffer_index), 2);
        for (int k = 0; k < 20 && issued_count != 2; k++) tick();
        check("t5_issued2", 32'(issued_count), 2);
        check("t5_pending_clear", 32'(pending), 0);

        // ---- flush mid-ISSUE (ready + slot_set in the same cycle are dropped)
        issue_ready = 1'b0;
        set_slot(4'd2);
        repeat (5) tick();
        check("t6_in_issue", 32'(issue_valid), 1);
        flush = 1'b1; issue_ready = 1'b1; slot_set = 1'b1; slot_set_index = 4'd9;
        tick();
        flush = 1'b0; issue_ready = 1'b0; slot_set = 1'b0;
        check("t6_valid", 32'(issue_valid), 0);
        check("t6_pending", 32'(pending), 0);
        check("t6_issued", 32'(issued_count), 2);
        check("t6_busy", 32'(busy), 0);

        // ---- async reset in WAIT, between clock edges
        set_slot(4'd4);
        tick();
        check("t7_wait_busy", 32'(busy), 1);
        check("t7_snapshot", 32'(core_independent_instr), 32'h0800);
        #2 rst = 1'b0;
        #1;
        check("t7_busy", 32'(busy), 0);
        check("t7_pending", 32'(pending), 0);
        check("t7_snapshot0", 32'(core_independent_instr), 0);
        check("t7_cbi", 32'(core_buffer_index), 0);
        check("t7_counts", {issued_count, miss_count}, 0);
        check("t7_strobes", {30'd0, core_proceed, issue_valid}, 0);
        rst = 1'b1;
        tick();

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
